// File: rtl/i2c_target.sv
// 7-bit-address I2C target: oversamples SCL/SDA, detects START/STOP, ACKs its
// address and every written byte, and streams read bytes from a user port.
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       system_clock,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rw,
    output logic       addr_match,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX,
        S_RX_ACK,
        S_TX,
        S_TX_ACK,
        S_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_prev_reg;
    logic                   sda_prev_reg;

    state_t     state_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic       ack_flag_reg;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_cond;
    logic stop_cond;

    // Sync flops reset high so a released bus never looks like an edge.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
            scl_prev_reg <= scl_s;
            sda_prev_reg <= sda_s;
        end
    end

    assign scl_s      = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s      = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_prev_reg;
    assign scl_fall   = ~scl_s & scl_prev_reg;
    assign start_cond = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
    assign stop_cond  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            ack_flag_reg <= 1'b0;
            sda_oe       <= 1'b0;
            tx_load      <= 1'b0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rw           <= 1'b0;
            addr_match   <= 1'b0;
            start_det    <= 1'b0;
            stop_det     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            tx_load    <= 1'b0;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
            if (start_cond) begin
                start_det    <= 1'b1;
                busy         <= 1'b1;
                bit_cnt_reg  <= 3'd0;
                ack_flag_reg <= 1'b0;
                sda_oe       <= 1'b0;
                state_reg    <= S_ADDR;
            end else if (stop_cond) begin
                stop_det  <= 1'b1;
                busy      <= 1'b0;
                sda_oe    <= 1'b0;
                state_reg <= S_IDLE;
            end else begin
                case (state_reg)
                    S_IDLE: sda_oe <= 1'b0;
                    S_ADDR: begin
                        if (scl_rise) begin
                            shift_reg   <= {shift_reg[6:0], sda_s};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                if (shift_reg[6:0] == ADDR) begin
                                    rw           <= sda_s;
                                    addr_match   <= 1'b1;
                                    ack_flag_reg <= 1'b0;
                                    state_reg    <= S_ADDR_ACK;
                                end else begin
                                    state_reg <= S_WAIT;
                                end
                            end
                        end
                    end
                    // First falling edge starts the ACK, second one ends it.
                    S_ADDR_ACK, S_RX_ACK: begin
                        if (scl_fall) begin
                            if (!ack_flag_reg) begin
                                sda_oe       <= 1'b1;
                                ack_flag_reg <= 1'b1;
                            end else begin
                                ack_flag_reg <= 1'b0;
                                bit_cnt_reg  <= 3'd0;
                                if (state_reg == S_ADDR_ACK && rw) begin
                                    tx_load   <= 1'b1;
                                    sda_oe    <= ~tx_data[7];
                                    shift_reg <= {tx_data[6:0], 1'b0};
                                    state_reg <= S_TX;
                                end else begin
                                    sda_oe    <= 1'b0;
                                    state_reg <= S_RX;
                                end
                            end
                        end
                    end
                    S_RX: begin
                        if (scl_rise) begin
                            shift_reg   <= {shift_reg[6:0], sda_s};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                rx_data      <= {shift_reg[6:0], sda_s};
                                rx_valid     <= 1'b1;
                                ack_flag_reg <= 1'b0;
                                state_reg    <= S_RX_ACK;
                            end
                        end
                    end
                    // MSB is already on the bus; each fall presents the next bit.
                    S_TX: begin
                        if (scl_fall) begin
                            if (bit_cnt_reg == 3'd7) begin
                                sda_oe       <= 1'b0;
                                ack_flag_reg <= 1'b0;
                                state_reg    <= S_TX_ACK;
                            end else begin
                                sda_oe      <= ~shift_reg[7];
                                shift_reg   <= {shift_reg[6:0], 1'b0};
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end
                    S_TX_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                ack_flag_reg <= 1'b1;
                            end else begin
                                state_reg <= S_WAIT;
                            end
                        end else if (scl_fall && ack_flag_reg) begin
                            ack_flag_reg <= 1'b0;
                            tx_load      <= 1'b1;
                            sda_oe       <= ~tx_data[7];
                            shift_reg    <= {tx_data[6:0], 1'b0};
                            bit_cnt_reg  <= 3'd0;
                            state_reg    <= S_TX;
                        end
                    end
                    S_WAIT:  sda_oe <= 1'b0;
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed + randomized bus-level bench for i2c_target; the bench acts as the
// I2C controller and predicts ACKs, received bytes and pulse counts itself.
module tb_i2c_target;

    localparam int Q = 10;
    localparam int H = 20;
    localparam logic [6:0] TGT = 7'h50;

    logic       system_clock;
    logic       reset_n;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic [7:0] tx_data;
    logic       sda_oe;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rw;
    logic       addr_match;
    logic       start_det;
    logic       stop_det;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0, tx_cnt = 0, am_cnt = 0, st_cnt = 0, sp_cnt = 0, oe_cnt = 0;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target #(.ADDR(TGT), .SYNC_STAGES(2)) dut (
        .system_clock(system_clock),
        .reset_n     (reset_n),
        .scl_in      (scl_m),
        .sda_in      (sda_bus),
        .sda_oe      (sda_oe),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rw          (rw),
        .addr_match  (addr_match),
        .start_det   (start_det),
        .stop_det    (stop_det),
        .busy        (busy)
    );

    initial system_clock = 1'b0;
    always #5 system_clock = ~system_clock;

    always @(posedge system_clock) begin
        if (rx_valid)   rx_cnt <= rx_cnt + 1;
        if (tx_load)    tx_cnt <= tx_cnt + 1;
        if (addr_match) am_cnt <= am_cnt + 1;
        if (start_det)  st_cnt <= st_cnt + 1;
        if (stop_det)   sp_cnt <= sp_cnt + 1;
        if (sda_oe)     oe_cnt <= oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(posedge system_clock);
        #2;
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wt(Q);
        scl_m = 1'b1; wt(H);
        sda_m = 1'b0; wt(H);
        scl_m = 1'b0; wt(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wt(Q);
        scl_m = 1'b1; wt(H);
        sda_m = 1'b1; wt(H);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wt(Q);
        scl_m = 1'b1; wt(H);
        scl_m = 1'b0; wt(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wt(Q);
        scl_m = 1'b1; wt(H / 2);
        ack = ~sda_bus; wt(H / 2);
        scl_m = 1'b0; wt(Q);
    endtask

    task automatic read_byte(input logic [7:0] next_tx, input logic m_ack, output logic [7:0] b);
        tx_data = next_tx;
        sda_m   = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wt(Q);
            scl_m = 1'b1; wt(H / 2);
            b[i] = sda_bus; wt(H / 2);
            scl_m = 1'b0;
        end
        sda_m = ~m_ack; wt(Q);
        scl_m = 1'b1;   wt(H);
        scl_m = 1'b0;   wt(Q);
        sda_m = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic       match;
        logic [6:0] a7;
        logic [7:0] d;
        logic [7:0] b;
        logic [7:0] rb;
        logic [7:0] exp_rx_data;
        int rx0, tx0, am0, st0, sp0, oe0;

        reset_n = 1'b0;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        tx_data = 8'h00;
        exp_rx_data = 8'h00;
        wt(5);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rw", rw, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {tx_load, rx_valid, addr_match, start_det, stop_det}, 0);
        reset_n = 1'b1;
        wt(5);

        // Plain write of 0x3C
        rx0 = rx_cnt; am0 = am_cnt; st0 = st_cnt; sp0 = sp_cnt;
        i2c_start;
        check("wr_busy", busy, 1);
        write_byte(8'hA0, ack);
        check("wr_addr_ack", ack, 1);
        check("wr_rw", rw, 0);
        write_byte(8'h3C, ack);
        check("wr_data_ack", ack, 1);
        i2c_stop;
        exp_rx_data = 8'h3C;
        check("wr_rx_cnt", rx_cnt - rx0, 1);
        check("wr_rx_data", rx_data, exp_rx_data);
        check("wr_addr_match", am_cnt - am0, 1);
        check("wr_start_cnt", st_cnt - st0, 1);
        check("wr_stop_cnt", sp_cnt - sp0, 1);
        check("wr_busy_end", busy, 0);

        // Randomized writes: matching or foreign address
        for (int it = 0; it < 4; it++) begin
            match = 1'($urandom_range(0, 1));
            a7    = 7'($urandom_range(0, 127));
            if (a7 == TGT) a7 = 7'h51;
            if (match) a7 = TGT;
            d   = 8'($urandom);
            rx0 = rx_cnt;
            i2c_start;
            write_byte({a7, 1'b0}, ack);
            check("rnd_addr_ack", ack, match);
            write_byte(d, ack);
            check("rnd_data_ack", ack, match);
            i2c_stop;
            if (match) exp_rx_data = d;
            check("rnd_rx_cnt", rx_cnt - rx0, match ? 1 : 0);
            check("rnd_rx_data", rx_data, exp_rx_data);
        end

        // Address mismatch: bus must never be pulled
        rx0 = rx_cnt; oe0 = oe_cnt;
        i2c_start;
        write_byte(8'hA2, ack);
        check("mm_addr_ack", ack, 0);
        write_byte(8'h55, ack);
        check("mm_data_ack", ack, 0);
        check("mm_busy_wait", busy, 1);
        i2c_stop;
        check("mm_oe_cycles", oe_cnt - oe0, 0);
        check("mm_rx_cnt", rx_cnt - rx0, 0);
        check("mm_busy_end", busy, 0);

        // Read 0x96 (ACK) then 0x5A (NACK)
        tx0 = tx_cnt;
        tx_data = 8'h96;
        i2c_start;
        write_byte(8'hA1, ack);
        check("rd_addr_ack", ack, 1);
        check("rd_rw", rw, 1);
        read_byte(8'h5A, 1'b1, b);
        check("rd_byte0", b, 8'h96);
        read_byte(8'h00, 1'b0, b);
        check("rd_byte1", b, 8'h5A);
        wt(Q);
        check("rd_oe_after_nack", sda_oe, 0);
        check("rd_tx_load_cnt", tx_cnt - tx0, 2);
        i2c_stop;

        // Repeated START: write 0x01 then read a random byte
        st0 = st_cnt; rx0 = rx_cnt; tx0 = tx_cnt;
        rb = 8'($urandom);
        i2c_start;
        write_byte(8'hA0, ack);
        check("rs_wr_addr_ack", ack, 1);
        write_byte(8'h01, ack);
        check("rs_wr_data_ack", ack, 1);
        exp_rx_data = 8'h01;
        tx_data = rb;
        i2c_start;
        write_byte(8'hA1, ack);
        check("rs_rd_addr_ack", ack, 1);
        check("rs_rw", rw, 1);
        read_byte(8'h00, 1'b0, b);
        check("rs_rd_byte", b, rb);
        i2c_stop;
        check("rs_start_cnt", st_cnt - st0, 2);
        check("rs_rx_cnt", rx_cnt - rx0, 1);
        check("rs_rx_data", rx_data, exp_rx_data);
        check("rs_tx_load_cnt", tx_cnt - tx0, 1);

        // STOP after half a data byte discards it
        rx0 = rx_cnt; sp0 = sp_cnt;
        d = 8'($urandom);
        i2c_start;
        write_byte(8'hA0, ack);
        check("part_addr_ack", ack, 1);
        for (int i = 7; i >= 4; i--) send_bit(d[i]);
        i2c_stop;
        check("part_rx_cnt", rx_cnt - rx0, 0);
        check("part_rx_data", rx_data, exp_rx_data);
        check("part_stop_cnt", sp_cnt - sp0, 1);
        check("part_busy", busy, 0);

        // STOP right after START with SCL held high
        st0 = st_cnt; sp0 = sp_cnt; am0 = am_cnt;
        sda_m = 1'b1; scl_m = 1'b1; wt(Q);
        sda_m = 1'b0; wt(H);
        sda_m = 1'b1; wt(H);
        check("ss_start_cnt", st_cnt - st0, 1);
        check("ss_stop_cnt", sp_cnt - sp0, 1);
        check("ss_busy", busy, 0);
        check("ss_addr_match", am_cnt - am0, 0);

        // Reset while driving a zero bit of a read
        tx_data = 8'h00;
        i2c_start;
        write_byte(8'hA1, ack);
        check("rst_tx_addr_ack", ack, 1);
        check("rst_tx_driving", sda_oe, 1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_oe", sda_oe, 0);
        check("rst_async_busy", busy, 0);
        wt(3);
        reset_n = 1'b1;
        exp_rx_data = 8'h00;
        oe0 = oe_cnt; am0 = am_cnt;
        sda_m = 1'b1;
        repeat (9) begin
            scl_m = 1'b1; wt(H);
            scl_m = 1'b0; wt(Q);
        end
        check("rst_quiet_oe", oe_cnt - oe0, 0);
        check("rst_quiet_match", am_cnt - am0, 0);
        i2c_stop;
        d = 8'($urandom);
        i2c_start;
        write_byte(8'hA0, ack);
        check("rst_fresh_addr_ack", ack, 1);
        write_byte(d, ack);
        check("rst_fresh_data_ack", ack, 1);
        i2c_stop;
        exp_rx_data = d;
        check("rst_fresh_rx_data", rx_data, exp_rx_data);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

Synthesizable 7-bit-address I2C target (slave) that sits on the `sda`/`scl` open-drain bus as the DUT consuming and answering the transactions the UVC drives. It oversamples both bus lines on the system clock, detects START/STOP, matches its address, ACKs, and hands received bytes to, and fetches transmit bytes from, a simple byte-wide user port. It never drives `scl` (no clock stretching) and only ever pulls `sda` low.

## Interface
- `ADDR`, 7'h50, target address compared against the first byte after START.
- `SYNC_STAGES`, 2, synchronizer flops per bus line (≥2).
- `system_clock` input 1: single clock, ≥10× `scl` frequency.
- `reset_n` input 1: asynchronous, active-low reset.
- `scl_in` input 1: bus SCL level.
- `sda_in` input 1: bus SDA level.
- `sda_oe` output 1: 1 = pull SDA low, 0 = release (external pull-up).
- `tx_data` input 8: byte to send on read; sampled on the `tx_load` cycle.
- `tx_load` output 1: 1-cycle pulse, `tx_data` latched into the shift register.
- `rx_data` output 8: last byte received in a write transfer; held until next.
- `rx_valid` output 1: 1-cycle pulse, `rx_data` updated.
- `rw` output 1: R/W bit of the last matched address (1 = read).
- `addr_match` output 1: 1-cycle pulse on address match.
- `start_det`, `stop_det` output 1: 1-cycle pulses on START (incl. repeated) / STOP.
- `busy` output 1: high from START to STOP.

## Operation
- Synchronize `scl_in`/`sda_in` through `SYNC_STAGES` flops, plus one history flop for edge detection; all logic below uses the synchronized values.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both override any state.
- Data sampled on SCL rising edge, MSB first; `sda_oe` updated only on SCL falling edge.
- 3-bit bit counter, cleared on START and on entry to each byte; wraps 7→0.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT.
  - IDLE: `sda_oe`=0; START → ADDR.
  - ADDR: shift 8 bits. 8th rising edge: address == `ADDR` → latch `rw`, pulse `addr_match`, go ADDR_ACK; else → WAIT.
  - ADDR_ACK: on the falling edge ending bit 8, `sda_oe`=1; on the falling edge ending the ACK bit, release (write) → RX, or (read) pulse `tx_load`, drive MSB → TX.
  - RX: shift 8 bits; 8th rising edge: update `rx_data`, pulse `rx_valid` → RX_ACK (ACK every byte, same drive/release timing as ADDR_ACK) → RX.
  - TX: drive bits on falling edges (`sda_oe` = ~bit); after the 8th bit's falling edge release → TX_ACK.
  - TX_ACK: sample on rising edge: SDA low (ACK) → on next falling edge `tx_load`, drive MSB, → TX; SDA high (NACK) → WAIT.
  - WAIT: `sda_oe`=0; ignore bus until START (→ ADDR) or STOP (→ IDLE).
- START in any state: `start_det`, `busy`=1, counter cleared, `sda_oe`=0, → ADDR. STOP in any state: `stop_det`, `busy`=0, `sda_oe`=0, → IDLE. Partial bytes discarded (no `rx_valid`).

## Timing
- Reset values: `sda_oe`=0, `rx_data`=8'h00, `rw`=0, all pulses 0, `busy`=0, state IDLE, sync flops 1 (idle bus).
- Pin-to-detect latency: `SYNC_STAGES`+1 cycles from bus edge to internal edge/condition.
- `sda_oe` changes the cycle after the internal SCL falling edge is detected.
- `rx_valid`, `addr_match` assert the cycle after the internal 8th rising edge.
- `tx_load` and the first `sda_oe` value of a TX byte occur in the same cycle.
- Reset asserted mid-transfer: outputs to reset values immediately (async); after release, block stays IDLE until a fresh START.
- START and STOP can't coincide; a STOP immediately after START (no SCL pulse) → IDLE with both pulses issued.

## Test plan
- Write: START, 0xA0, 0x3C, STOP → ACK on address and data, `addr_match`=1, `rw`=0, one `rx_valid` with `rx_data`=0x3C, `stop_det`, `busy`=0.
- Mismatch: START, 0xA2, 0x55 → `sda_oe` never asserted, no `rx_valid`, state WAIT until STOP.
- Read: START, 0xA1, `tx_data`=0x96 then 0x5A, master ACKs first and NACKs second → bus shows 0x96, 0x5A, two `tx_load` pulses, `sda_oe`=0 after NACK.
- Repeated START: write 0xA0, 0x01, then START, 0xA1 → `start_det` twice, `rw`=1, read proceeds.
- STOP after 4 bits of a data byte → no `rx_valid`, `rx_data` unchanged, IDLE.
- `reset_n` low during TX with `sda_oe`=1 → `sda_oe`=0 asynchronously, no response until next START.
